// File: rtl/johnson_counter_param_if.sv
// Control and status bundle for johnson_counter_param.
// The master drives the load/step controls and the slave (the counter) returns its state.
interface johnson_counter_param_if #(
  parameter int unsigned WIDTH = 4
);
  localparam int unsigned IW = $clog2(2 * WIDTH);

  logic             preset;
  logic [WIDTH-1:0] load_cnt;
  logic             en;
  logic             dir;
  logic [WIDTH-1:0] count;
  logic [IW-1:0]    state_idx;
  logic             illegal;
  logic             wrap;

  modport master (
    output preset, load_cnt, en, dir,
    input  count, state_idx, illegal, wrap
  );

  modport slave (
    input  preset, load_cnt, en, dir,
    output count, state_idx, illegal, wrap
  );
endinterface

// File: rtl/johnson_counter_param.sv
// Parametrised Johnson/ring shift counter with direction control, synchronous load,
// illegal-state detection with optional self-correction, sequence index decode and wrap pulse.
module johnson_counter_param #(
  parameter int unsigned WIDTH        = 4,
  parameter int unsigned MODE         = 0,
  parameter int unsigned SELF_CORRECT = 1
) (
  input logic                     clk,
  input logic                     clear,
  johnson_counter_param_if.slave  bus
);
  localparam int unsigned      IW     = $clog2(2 * WIDTH);
  localparam logic [WIDTH-1:0] RstVal = (MODE == 0) ? '0 : WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d, shifted;
  logic             wrap_q, wrap_d;
  logic             legal, msb_run, lsb_run;
  logic [IW-1:0]    idx;
  int unsigned      pop, pos;

  // Popcount, set-bit position and the two anchored-run tests.
  always_comb begin
    pop     = 0;
    pos     = 0;
    msb_run = 1'b1;
    lsb_run = 1'b1;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (count_q[i]) begin
        pop = pop + 1;
        pos = i;
      end
    end
    for (int i = 0; i < int'(WIDTH) - 1; i++) begin
      if (count_q[i] && !count_q[i+1]) msb_run = 1'b0;
      if (count_q[i+1] && !count_q[i]) lsb_run = 1'b0;
    end
  end

  always_comb begin
    if (MODE == 0) begin
      legal = msb_run | lsb_run;
    end else begin
      legal = (pop == 1);
    end

    idx = '0;
    if (legal) begin
      if (MODE == 0) begin
        if (count_q[WIDTH-1]) begin
          idx = IW'(pop);
        end else begin
          idx = IW'((2 * WIDTH - pop) % (2 * WIDTH));
        end
      end else begin
        idx = IW'((WIDTH - pos) % WIDTH);
      end
    end
  end

  always_comb begin
    if (MODE == 0) begin
      shifted = bus.dir ? {~count_q[0], count_q[WIDTH-1:1]}
                        : {count_q[WIDTH-2:0], ~count_q[WIDTH-1]};
    end else begin
      shifted = bus.dir ? {count_q[0], count_q[WIDTH-1:1]}
                        : {count_q[WIDTH-2:0], count_q[WIDTH-1]};
    end
  end

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (!bus.preset) begin
      count_d = bus.load_cnt;
    end else if (bus.en) begin
      if (!legal && (SELF_CORRECT != 0)) begin
        count_d = RstVal;
      end else begin
        count_d = shifted;
        // Only a legal trajectory returning home counts as a wrap.
        wrap_d  = legal && (shifted == RstVal);
      end
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      count_q <= RstVal;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.count     = count_q;
  assign bus.wrap      = wrap_q;
  assign bus.illegal   = ~legal;
  assign bus.state_idx = idx;
endmodule

// File: tb/tb_johnson_counter_param.sv
// Directed bench for johnson_counter_param across Johnson (with/without self-correction),
// ring and wide Johnson configurations sharing one clock and reset.
module tb_johnson_counter_param;
  logic       clk;
  logic       clear;
  logic       preset;
  logic       en;
  logic       dir;
  logic [3:0] ld4;
  logic [4:0] ld5;
  logic [7:0] ld8;

  int checks;
  int errors;

  johnson_counter_param_if #(.WIDTH(4)) b4  ();
  johnson_counter_param_if #(.WIDTH(4)) b4n ();
  johnson_counter_param_if #(.WIDTH(5)) b5  ();
  johnson_counter_param_if #(.WIDTH(8)) b8  ();

  assign b4.preset   = preset;
  assign b4.en       = en;
  assign b4.dir      = dir;
  assign b4.load_cnt = ld4;
  assign b4n.preset   = preset;
  assign b4n.en       = en;
  assign b4n.dir      = dir;
  assign b4n.load_cnt = ld4;
  assign b5.preset   = preset;
  assign b5.en       = en;
  assign b5.dir      = dir;
  assign b5.load_cnt = ld5;
  assign b8.preset   = preset;
  assign b8.en       = en;
  assign b8.dir      = dir;
  assign b8.load_cnt = ld8;

  johnson_counter_param #(.WIDTH(4), .MODE(0), .SELF_CORRECT(1)) u_j4 (
    .clk(clk), .clear(clear), .bus(b4.slave)
  );
  johnson_counter_param #(.WIDTH(4), .MODE(0), .SELF_CORRECT(0)) u_j4n (
    .clk(clk), .clear(clear), .bus(b4n.slave)
  );
  johnson_counter_param #(.WIDTH(5), .MODE(1), .SELF_CORRECT(1)) u_r5 (
    .clk(clk), .clear(clear), .bus(b5.slave)
  );
  johnson_counter_param #(.WIDTH(8), .MODE(0), .SELF_CORRECT(1)) u_j8 (
    .clk(clk), .clear(clear), .bus(b8.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    preset = 1'b1;
    en     = 1'b0;
    dir    = 1'b1;
    clear  = 1'b0;
    #2;
    clear  = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    logic [3:0] seq [8];
    logic [2:0] eidx;
    seq[0] = 4'b1000; seq[1] = 4'b1100; seq[2] = 4'b1110; seq[3] = 4'b1111;
    seq[4] = 4'b0111; seq[5] = 4'b0011; seq[6] = 4'b0001; seq[7] = 4'b0000;
    preset = 1'b1;
    en     = 1'b1;
    dir    = 1'b1;
    clear  = 1'b0;
    #2;
    checks++;
    if (b4.count !== 4'b0000 || b4.wrap !== 1'b0 || b4.state_idx !== 3'd0
        || b4.illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: count=%b wrap=%b idx=%0d illegal=%b want 0000 0 0 0",
               b4.count, b4.wrap, b4.state_idx, b4.illegal);
    end
    clear = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      eidx = 3'((i + 1) % 8);
      checks++;
      if (b4.count !== seq[i] || b4.state_idx !== eidx || b4.wrap !== (i == 7)) begin
        errors++;
        $display("FAIL legacy_seq[%0d]: count=%b idx=%0d wrap=%b want %b %0d %b",
                 i, b4.count, b4.state_idx, b4.wrap, seq[i], eidx, (i == 7));
      end
    end
    en = 1'b0;
    tick();
    checks++;
    if (b4.wrap !== 1'b0 || b4.count !== 4'b0000) begin
      errors++;
      $display("FAIL hold_after_wrap: count=%b wrap=%b want 0000 0", b4.count, b4.wrap);
    end
  endtask

  task automatic test_direction();
    logic [3:0] seq [4];
    logic [2:0] eidx [4];
    logic       ewrap [4];
    seq[0] = 4'b1100; eidx[0] = 3'd2; ewrap[0] = 1'b0;
    seq[1] = 4'b1000; eidx[1] = 3'd1; ewrap[1] = 1'b0;
    seq[2] = 4'b0000; eidx[2] = 3'd0; ewrap[2] = 1'b1;
    seq[3] = 4'b0001; eidx[3] = 3'd7; ewrap[3] = 1'b0;
    do_reset();
    en = 1'b1;
    dir = 1'b1;
    repeat (3) tick();
    checks++;
    if (b4.count !== 4'b1110 || b4.state_idx !== 3'd3) begin
      errors++;
      $display("FAIL dir_setup: count=%b idx=%0d want 1110 3", b4.count, b4.state_idx);
    end
    dir = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (b4.count !== seq[i] || b4.state_idx !== eidx[i] || b4.wrap !== ewrap[i]) begin
        errors++;
        $display("FAIL dir_rev[%0d]: count=%b idx=%0d wrap=%b want %b %0d %b",
                 i, b4.count, b4.state_idx, b4.wrap, seq[i], eidx[i], ewrap[i]);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_load_priority();
    do_reset();
    en = 1'b1;
    dir = 1'b1;
    repeat (6) tick();
    checks++;
    if (b4.count !== 4'b0011) begin
      errors++;
      $display("FAIL load_setup: count=%b want 0011", b4.count);
    end
    preset = 1'b0;
    ld4    = 4'b1111;
    tick();
    checks++;
    if (b4.count !== 4'b1111 || b4.state_idx !== 3'd4 || b4.wrap !== 1'b0) begin
      errors++;
      $display("FAIL load_over_en: count=%b idx=%0d wrap=%b want 1111 4 0",
               b4.count, b4.state_idx, b4.wrap);
    end
    ld4 = 4'b0101;
    #2;
    clear = 1'b0;
    tick();
    checks++;
    if (b4.count !== 4'b0000) begin
      errors++;
      $display("FAIL clear_over_load: count=%b want 0000", b4.count);
    end
    clear  = 1'b1;
    preset = 1'b1;
    en     = 1'b0;
  endtask

  task automatic test_illegal();
    do_reset();
    preset = 1'b0;
    ld4    = 4'b0101;
    tick();
    preset = 1'b1;
    checks++;
    if (b4.illegal !== 1'b1 || b4.state_idx !== 3'd0 || b4.count !== 4'b0101) begin
      errors++;
      $display("FAIL illegal_flag: count=%b illegal=%b idx=%0d want 0101 1 0",
               b4.count, b4.illegal, b4.state_idx);
    end
    checks++;
    if (b4n.illegal !== 1'b1 || b4n.state_idx !== 3'd0) begin
      errors++;
      $display("FAIL illegal_flag_nc: illegal=%b idx=%0d want 1 0", b4n.illegal, b4n.state_idx);
    end
    en  = 1'b1;
    dir = 1'b1;
    tick();
    checks++;
    if (b4.count !== 4'b0000 || b4.wrap !== 1'b0 || b4.illegal !== 1'b0) begin
      errors++;
      $display("FAIL self_correct: count=%b wrap=%b illegal=%b want 0000 0 0",
               b4.count, b4.wrap, b4.illegal);
    end
    checks++;
    if (b4n.count !== 4'b0010 || b4n.wrap !== 1'b0) begin
      errors++;
      $display("FAIL no_correct: count=%b wrap=%b want 0010 0", b4n.count, b4n.wrap);
    end
    en = 1'b0;
  endtask

  task automatic test_ring();
    logic [4:0] seq [5];
    logic [3:0] eidx;
    seq[0] = 5'b10000; seq[1] = 5'b01000; seq[2] = 5'b00100;
    seq[3] = 5'b00010; seq[4] = 5'b00001;
    do_reset();
    checks++;
    if (b5.count !== 5'b00001 || b5.state_idx !== 4'd0 || b5.illegal !== 1'b0) begin
      errors++;
      $display("FAIL ring_reset: count=%b idx=%0d illegal=%b want 00001 0 0",
               b5.count, b5.state_idx, b5.illegal);
    end
    en  = 1'b1;
    dir = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      eidx = 4'((i + 1) % 5);
      checks++;
      if (b5.count !== seq[i] || b5.state_idx !== eidx || b5.wrap !== (i == 4)) begin
        errors++;
        $display("FAIL ring_seq[%0d]: count=%b idx=%0d wrap=%b want %b %0d %b",
                 i, b5.count, b5.state_idx, b5.wrap, seq[i], eidx, (i == 4));
      end
    end
    en     = 1'b0;
    preset = 1'b0;
    ld5    = 5'b00000;
    tick();
    preset = 1'b1;
    checks++;
    if (b5.illegal !== 1'b1 || b5.state_idx !== 4'd0) begin
      errors++;
      $display("FAIL ring_illegal: illegal=%b idx=%0d want 1 0", b5.illegal, b5.state_idx);
    end
    en = 1'b1;
    tick();
    checks++;
    if (b5.count !== 5'b00001 || b5.wrap !== 1'b0) begin
      errors++;
      $display("FAIL ring_correct: count=%b wrap=%b want 00001 0", b5.count, b5.wrap);
    end
    en = 1'b0;
  endtask

  task automatic test_async_mid();
    do_reset();
    en  = 1'b1;
    dir = 1'b1;
    repeat (4) tick();
    checks++;
    if (b8.count !== 8'b11110000 || b8.state_idx !== 4'd4) begin
      errors++;
      $display("FAIL async_setup: count=%b idx=%0d want 11110000 4", b8.count, b8.state_idx);
    end
    #2;
    clear = 1'b0;
    #1;
    checks++;
    if (b8.count !== 8'b00000000 || b8.wrap !== 1'b0 || b8.state_idx !== 4'd0) begin
      errors++;
      $display("FAIL async_clear: count=%b wrap=%b idx=%0d want 00000000 0 0",
               b8.count, b8.wrap, b8.state_idx);
    end
    clear = 1'b1;
    tick();
    checks++;
    if (b8.count !== 8'b10000000 || b8.state_idx !== 4'd1) begin
      errors++;
      $display("FAIL async_resume: count=%b idx=%0d want 10000000 1", b8.count, b8.state_idx);
    end
    en = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clear  = 1'b0;
    preset = 1'b1;
    en     = 1'b0;
    dir    = 1'b1;
    ld4    = '0;
    ld5    = '0;
    ld8    = '0;
    #2;
    test_reset();
    test_direction();
    test_load_priority();
    test_illegal();
    test_ring();
    test_async_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/johnson_counter_param.md
Name: johnson_counter_param

Overview:
Parametrised shift-register counter that replaces the fixed 4-bit Johnson counter with preset. It supports:
- Johnson (twisted-ring) or ring mode, selected at elaboration.
- Run-time direction control and a count enable.
- Synchronous active-low load.
- Illegal-state detection and optional self-correction.
- A decoded sequence index and a wrap pulse.

It is used as a low-glitch sequencer and phase generator in the small-scale counter library.

Parameters:
WIDTH, 4, register width; must be at least 2.
MODE, 0, 0 = Johnson (2*WIDTH states), 1 = ring (WIDTH states).
SELF_CORRECT, 1, 1 = an enabled step from an illegal state forces RST_VAL; 0 = illegal states shift normally.

Ports:
clk  input  1  rising-edge clock
clear  input  1  asynchronous active-low reset
preset  input  1  synchronous active-low load strobe
load_cnt  input  WIDTH  value loaded when preset=0
en  input  1  count enable
dir  input  1  1 = shift toward LSB (legacy order), 0 = shift toward MSB
count  output  WIDTH  counter state (registered)
state_idx  output  IW = $clog2(2*WIDTH)  sequence index of count (combinational)
illegal  output  1  count is not a legal state for MODE (combinational)
wrap  output  1  one-cycle pulse, registered

Behaviour:
- RST_VAL: all zeros when MODE=0; 1 (only bit 0 set) when MODE=1.
- Reset: clear=0 forces count=RST_VAL and wrap=0 immediately, independent of clk.
  - Reset asserted mid-sequence aborts it; there is no pending state.
  - The first clk edge after clear rises is evaluated normally.
- Priority at each clk edge: clear, then preset=0 (load), then en=1 (step), otherwise hold.
- Load: count <= load_cnt verbatim, illegal values included. Load ignores en and dir. wrap <= 0.
- Step, Johnson mode:
  - dir=1: count <= {~count[0], count[W-1:1]}
  - dir=0: count <= {count[W-2:0], ~count[W-1]}
- Step, ring mode:
  - dir=1: count <= {count[0], count[W-1:1]}
  - dir=0: count <= {count[W-2:0], count[W-1]}
- Legal states:
  - Johnson: count is a contiguous run of ones anchored at the MSB (1..1 0..0) or at the LSB (0..0 1..1). This includes all-zeros and all-ones.
  - Ring: exactly one bit set.
- illegal = NOT legal(count), evaluated combinationally.
- Self-correction: with SELF_CORRECT=1, en=1, preset=1 and illegal=1, count <= RST_VAL regardless of dir, and wrap <= 0. With SELF_CORRECT=0 the shift rule applies unchanged.
- state_idx is the number of dir=1 steps from RST_VAL to count; it is 0 when illegal=1.
  - Johnson: if count[W-1]=1, idx = popcount(count). Otherwise idx = (2*WIDTH - popcount) mod 2*WIDTH.
  - Ring: with p = position of the set bit, idx = (WIDTH - p) mod WIDTH.
- wrap <= 1 only on an enabled step from a legal state whose next value equals RST_VAL, in either direction. wrap is therefore high during the cycle in which count == RST_VAL. Otherwise wrap <= 0.
- Hold (en=0, preset=1): count unchanged, wrap <= 0.
- dir may change on any cycle. The next step uses the new dir; there is no extra latency.
- Latency: count and wrap update 1 cycle after the qualifying edge. state_idx and illegal follow count combinationally.

Test Plan:
1. Reset/legacy order. Setup: WIDTH=4, MODE=0, clear pulse, then en=1, dir=1 for 8 cycles. Required: count runs 0000,1000,1100,1110,1111,0111,0011,0001,0000; state_idx runs 0..7 then 0; wrap=1 only in the cycle count returns to 0000.
2. Direction reversal. From 1110 (idx 3), set dir=0. Required: count goes 1100, 1000, 0000 with wrap=1 on reaching 0000; the next step gives 0001 with idx 7.
3. Load priority. At count=0011, drive preset=0, en=1, load_cnt=1111. Required: next count=1111, idx 4, wrap=0. Separately, assert clear with preset=0 at the same edge. Required: count=0000.
4. Illegal correction. Load 0101. Required: illegal=1 and state_idx=0. Then en=1. Required: with SELF_CORRECT=1 the next count is 0000 with wrap=0; with SELF_CORRECT=0 the next count is 0010 for dir=1.
5. Ring mode. Setup: WIDTH=5, MODE=1, reset. Required: count=00001. Then dir=1 for 5 steps. Required: 10000, 01000, 00100, 00010, 00001 with idx 1,2,3,4,0 and wrap on the last step. Then load 00000. Required: illegal=1; the next enabled step gives 00001.
6. Async reset mid-run. Setup: WIDTH=8, MODE=0, en=1, assert clear between clock edges at count=11110000. Required: count=00000000 and wrap=0 before the next edge; counting resumes from idx 0 after release.
